race_screen_sequencer: RTL and testbench
========================================

# race_screen_sequencer

Top-level screen state machine for the LED racer. Owns the game phase (menu, countdown, race, winner display) and drives the `is_in_menu` level that the finish detector and player-position logic consume. Watches the four player positions during a race, latches the winner on the first finish, holds a blinking winner display, then returns to the menu.

## Interface
- `MAX_POS`, 109: track length; finish position is `MAX_POS-1`.
- `TICK_DIV`, 25_000_000: clock cycles per display tick (at least 2).
- `COUNTDOWN_TICKS`, 3: ticks spent in countdown (1..3).
- `WIN_HOLD_TICKS`, 6: ticks spent in winner display (at least 1).
- `clk` in 1: system clock, all logic rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `btn_green`, `btn_red`, `btn_blue`, `btn_yellow` in 1 each: synchronized, debounced button levels, active-high.
- `green_cur_pos`, `red_cur_pos`, `blue_cur_pos`, `yellow_cur_pos` in `$clog2(MAX_POS)` each: current player positions.
- `is_in_menu` out 1: high in MENU.
- `positions_clear` out 1: one-cycle pulse telling position counters to return to 0.
- `race_enable` out 1: high in RACE only; position counters advance only while high.
- `countdown_value` out 2: remaining countdown ticks, 0 outside COUNTDOWN.
- `winner` out 4: one-hot {yellow, red, blue, green} = bits {3,2,1,0}. Valid in WINNER, 0 otherwise.
- `blink` out 1: toggles every tick in WINNER, 0 otherwise.

## Operation
- States: MENU, COUNTDOWN, RACE, WINNER. State is registered. All outputs are registered or decoded from registers; no input reaches an output combinationally.
- Button edge detect:
  - Register the previous level of each button.
  - `press = |(btn & ~btn_prev)`.
  - `btn_prev` resets to 4'b1111, so a button held through reset does not generate a press.
- Tick divider:
  - Counter runs 0..TICK_DIV-1.
  - `tick` asserts on the TICK_DIV-1 count.
  - The counter clears to 0 on every state transition, so each state starts with a full tick period.
- MENU:
  - `is_in_menu`=1.
  - On `press`: assert `positions_clear` for one cycle, load the tick-remaining counter with COUNTDOWN_TICKS, go to COUNTDOWN.
- COUNTDOWN:
  - `countdown_value` = remaining ticks.
  - Each `tick` decrements it.
  - When a tick arrives with remaining = 1, go to RACE and set `countdown_value` to 0.
  - Buttons are ignored.
- RACE:
  - `race_enable`=1.
  - Finish is `pos == MAX_POS-1` for any player.
  - On the first cycle with any finish, latch `winner` and go to WINNER. If several players finish in the same cycle, priority is green > red > blue > yellow, and exactly one bit is set.
  - Buttons do not change the state.
- WINNER:
  - `winner` is held.
  - `blink` starts at 1 on entry and toggles on each `tick`.
  - After WIN_HOLD_TICKS ticks, go to MENU and clear `winner` and `blink`.
  - Buttons are ignored. A press during WINNER does not carry into MENU, because edge detection uses levels only.
- Reset may be asserted mid-operation in any state. It immediately forces MENU and all output reset values.

## Timing
- Reset values:
  - `is_in_menu`=1
  - `positions_clear`=0
  - `race_enable`=0
  - `countdown_value`=0
  - `winner`=0
  - `blink`=0
  - divider=0
  - `btn_prev`=4'b1111
- Press latency: a button rises at edge N. `positions_clear`=1 and `is_in_menu`=0 after edge N+1 (one cycle wide). `countdown_value`=COUNTDOWN_TICKS is also visible from N+1.
- Countdown duration: exactly COUNTDOWN_TICKS*TICK_DIV cycles from COUNTDOWN entry to `race_enable`=1.
- Finish latency: a position reaches MAX_POS-1 at edge M. `race_enable`=0 and `winner` are valid after edge M+1. A finish visible on the same cycle that RACE is entered is honored.
- Winner hold: exactly WIN_HOLD_TICKS*TICK_DIV cycles, then `is_in_menu`=1.
- Width rules:
  - `countdown_value` saturates at parameter range 1..3.
  - The hold counter is `$clog2(WIN_HOLD_TICKS+1)` bits.
  - Divider width is `$clog2(TICK_DIV)`.

## Test plan
- Bench parameters: TICK_DIV=4, COUNTDOWN_TICKS=3, WIN_HOLD_TICKS=2, MAX_POS=109.
- Reset, then hold `btn_red`=1 through reset release: stays in MENU, `positions_clear` never pulses; release then press `btn_blue` -> one-cycle `positions_clear`, `countdown_value`=3.
- Countdown: `countdown_value` reads 3, 2, 1 for 4 cycles each, then `race_enable`=1 exactly 12 cycles after COUNTDOWN entry.
- In RACE, drive `red_cur_pos`=108 -> one cycle later `winner`=4'b0100 and `race_enable`=0. `blink` goes 1 then 0 after 4 cycles. `is_in_menu`=1 after 8 cycles.
- Simultaneous finish: set green, blue and yellow to 108 in the same cycle -> `winner`=4'b0001.
- Press buttons during COUNTDOWN and WINNER -> state and timing unchanged. Assert `rst_n`=0 mid-RACE -> all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/race_screen_sequencer_if.sv
// Signal bundle between the screen sequencer and the rest of the racer.
//   master : drives buttons and player positions, observes screen status
//   slave  : the sequencer itself
// Signals:
//   btn_*          debounced button levels, active-high
//   *_cur_pos      current player positions, $clog2(MAX_POS) bits
//   is_in_menu     high while the menu is shown
//   positions_clear one-cycle pulse, position counters return to 0
//   race_enable    position counters may advance
//   countdown_value remaining countdown ticks
//   winner         one-hot {yellow, red, blue, green}
//   blink          winner display blink phase
interface race_screen_sequencer_if #(
   parameter int MAX_POS = 109
) ();
   localparam int PW = $clog2(MAX_POS);

   logic          btn_green;
   logic          btn_red;
   logic          btn_blue;
   logic          btn_yellow;
   logic [PW-1:0] green_cur_pos;
   logic [PW-1:0] red_cur_pos;
   logic [PW-1:0] blue_cur_pos;
   logic [PW-1:0] yellow_cur_pos;
   logic          is_in_menu;
   logic          positions_clear;
   logic          race_enable;
   logic [1:0]    countdown_value;
   logic [3:0]    winner;
   logic          blink;

   modport master (
      output btn_green, btn_red, btn_blue, btn_yellow,
      output green_cur_pos, red_cur_pos, blue_cur_pos, yellow_cur_pos,
      input  is_in_menu, positions_clear, race_enable, countdown_value, winner, blink
   );

   modport slave (
      input  btn_green, btn_red, btn_blue, btn_yellow,
      input  green_cur_pos, red_cur_pos, blue_cur_pos, yellow_cur_pos,
      output is_in_menu, positions_clear, race_enable, countdown_value, winner, blink
   );
endinterface

// File: rtl/race_screen_sequencer.sv
// Screen state machine for the LED racer: menu, countdown, race, winner display.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   io_bus race_screen_sequencer_if.slave (buttons, positions in; screen status out)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// MENU      | idle, waiting for a fresh button press
// COUNTDOWN | counting COUNTDOWN_TICKS ticks down before the race
// RACE      | position counters enabled, watching for the first finish
// WINNER    | winner latched, blinking for WIN_HOLD_TICKS ticks
module race_screen_sequencer #(
   parameter int MAX_POS         = 109,
   parameter int TICK_DIV        = 25_000_000,
   parameter int COUNTDOWN_TICKS = 3,
   parameter int WIN_HOLD_TICKS  = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   race_screen_sequencer_if.slave  io_bus
);
   localparam int PW     = $clog2(MAX_POS);
   localparam int DIV_W  = $clog2(TICK_DIV);
   localparam int HOLD_W = $clog2(WIN_HOLD_TICKS + 1);
   localparam int CD_SAT = (COUNTDOWN_TICKS < 1) ? 1 :
                           (COUNTDOWN_TICKS > 3) ? 3 : COUNTDOWN_TICKS;

   localparam logic [PW-1:0]     FINISH_POS = PW'(MAX_POS - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(WIN_HOLD_TICKS);
   localparam logic [1:0]        CD_INIT    = 2'(CD_SAT);

   typedef enum logic [1:0] {
      MENU      = 2'd0,
      COUNTDOWN = 2'd1,
      RACE      = 2'd2,
      WINNER    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [DIV_W-1:0]  r_div;
   logic [3:0]        r_btn_prev;
   logic [1:0]        r_cd;
   logic [HOLD_W-1:0] r_hold;
   logic [3:0]        r_winner;
   logic              r_blink;
   logic              r_clear;

   logic [1:0]        w_cd_nxt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [3:0]        w_winner_nxt;
   logic              w_blink_nxt;
   logic              w_clear_nxt;
   logic [3:0]        w_btn;
   logic [3:0]        w_fin;
   logic              w_press;
   logic              w_tick;

   // Bit order matches the winner encoding: {yellow, red, blue, green}.
   assign w_btn   = {io_bus.btn_yellow, io_bus.btn_red, io_bus.btn_blue, io_bus.btn_green};
   assign w_fin   = {io_bus.yellow_cur_pos == FINISH_POS, io_bus.red_cur_pos == FINISH_POS,
                     io_bus.blue_cur_pos == FINISH_POS, io_bus.green_cur_pos == FINISH_POS};
   assign w_press = |(w_btn & ~r_btn_prev);
   assign w_tick  = (r_div == DIV_LAST);

   always_comb begin
      w_next       = r_state;
      w_cd_nxt     = r_cd;
      w_hold_nxt   = r_hold;
      w_winner_nxt = r_winner;
      w_blink_nxt  = r_blink;
      w_clear_nxt  = 1'b0;
      case (r_state)
         MENU: begin
            if (w_press) begin
               w_next      = COUNTDOWN;
               w_clear_nxt = 1'b1;
               w_cd_nxt    = CD_INIT;
            end
         end
         COUNTDOWN: begin
            if (w_tick) begin
               if (r_cd == 2'd1) begin
                  w_next   = RACE;
                  w_cd_nxt = 2'd0;
               end else begin
                  w_cd_nxt = r_cd - 2'd1;
               end
            end
         end
         RACE: begin
            if (|w_fin) begin
               w_next      = WINNER;
               w_blink_nxt = 1'b1;
               w_hold_nxt  = HOLD_INIT;
               // Tie break green > red > blue > yellow.
               if (w_fin[0])      w_winner_nxt = 4'b0001;
               else if (w_fin[2]) w_winner_nxt = 4'b0100;
               else if (w_fin[1]) w_winner_nxt = 4'b0010;
               else               w_winner_nxt = 4'b1000;
            end
         end
         WINNER: begin
            if (w_tick) begin
               if (r_hold == HOLD_W'(1)) begin
                  w_next       = MENU;
                  w_winner_nxt = 4'b0000;
                  w_blink_nxt  = 1'b0;
                  w_hold_nxt   = '0;
               end else begin
                  w_hold_nxt  = r_hold - HOLD_W'(1);
                  w_blink_nxt = ~r_blink;
               end
            end
         end
         default: w_next = MENU;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= MENU;
         r_div      <= '0;
         r_btn_prev <= 4'b1111;
         r_cd       <= 2'd0;
         r_hold     <= '0;
         r_winner   <= 4'b0000;
         r_blink    <= 1'b0;
         r_clear    <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_btn_prev <= w_btn;
         r_cd       <= w_cd_nxt;
         r_hold     <= w_hold_nxt;
         r_winner   <= w_winner_nxt;
         r_blink    <= w_blink_nxt;
         r_clear    <= w_clear_nxt;
         // Restarting on each transition gives every state a full first tick.
         if (w_next != r_state || w_tick) r_div <= '0;
         else                             r_div <= r_div + DIV_W'(1);
      end
   end

   assign io_bus.is_in_menu      = (r_state == MENU);
   assign io_bus.race_enable     = (r_state == RACE);
   assign io_bus.positions_clear = r_clear;
   assign io_bus.countdown_value = r_cd;
   assign io_bus.winner          = r_winner;
   assign io_bus.blink           = r_blink;
endmodule

// File: tb/tb_race_screen_sequencer.sv
module tb_race_screen_sequencer;
   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;

   race_screen_sequencer_if #(.MAX_POS(109)) bus ();

   race_screen_sequencer #(
      .MAX_POS(109), .TICK_DIV(4), .COUNTDOWN_TICKS(3), .WIN_HOLD_TICKS(2)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_menu"},  32'(bus.is_in_menu), 32'd1);
      chk({tag, "_clr"},   32'(bus.positions_clear), 32'd0);
      chk({tag, "_race"},  32'(bus.race_enable), 32'd0);
      chk({tag, "_cd"},    32'(bus.countdown_value), 32'd0);
      chk({tag, "_win"},   32'(bus.winner), 32'd0);
      chk({tag, "_blink"}, 32'(bus.blink), 32'd0);
   endtask

   task automatic clear_pos();
      bus.green_cur_pos  = '0;
      bus.red_cur_pos    = '0;
      bus.blue_cur_pos   = '0;
      bus.yellow_cur_pos = '0;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      bus.btn_green  = 1'b0;
      bus.btn_red    = 1'b1;
      bus.btn_blue   = 1'b0;
      bus.btn_yellow = 1'b0;
      clear_pos();
      step();
      step();
      chk_reset_outputs("rst");

      // Red held through reset release must not count as a press.
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("held_clr", 32'(bus.positions_clear), 32'd0);
         chk("held_menu", 32'(bus.is_in_menu), 32'd1);
      end
      bus.btn_red = 1'b0;
      step();
      chk("rel_menu", 32'(bus.is_in_menu), 32'd1);

      // Blue press: entry edge E is the next edge.
      bus.btn_blue = 1'b1;
      step();
      chk("press_clr", 32'(bus.positions_clear), 32'd1);
      chk("press_menu", 32'(bus.is_in_menu), 32'd0);
      chk("press_cd", 32'(bus.countdown_value), 32'd3);
      for (int k = 1; k < 12; k++) begin
         if (k == 2) bus.btn_blue = 1'b0;
         if (k == 5) bus.btn_green = 1'b1;
         if (k == 7) bus.btn_green = 1'b0;
         step();
         chk("cd_clr", 32'(bus.positions_clear), 32'd0);
         chk("cd_val", 32'(bus.countdown_value), 32'(3 - k / 4));
         chk("cd_race", 32'(bus.race_enable), 32'd0);
      end
      step();
      chk("race_on", 32'(bus.race_enable), 32'd1);
      chk("race_cd0", 32'(bus.countdown_value), 32'd0);
      bus.btn_red = 1'b1;
      step();
      chk("race_btn", 32'(bus.race_enable), 32'd1);
      bus.btn_red = 1'b0;
      bus.red_cur_pos = 7'd100;
      step();
      chk("race_near", 32'(bus.race_enable), 32'd1);

      // Red finishes.
      bus.red_cur_pos = 7'd108;
      step();
      chk("win_red", 32'(bus.winner), 32'b0100);
      chk("win_race", 32'(bus.race_enable), 32'd0);
      chk("win_blink0", 32'(bus.blink), 32'd1);
      for (int k = 1; k < 8; k++) begin
         if (k == 2) bus.btn_yellow = 1'b1;
         step();
         chk("hold_blink", 32'(bus.blink), 32'(k < 4));
         chk("hold_win", 32'(bus.winner), 32'b0100);
         chk("hold_menu", 32'(bus.is_in_menu), 32'd0);
      end
      clear_pos();
      step();
      chk("back_menu", 32'(bus.is_in_menu), 32'd1);
      chk("back_win", 32'(bus.winner), 32'd0);
      chk("back_blink", 32'(bus.blink), 32'd0);
      // Yellow still held from WINNER: no press in MENU.
      for (int k = 0; k < 3; k++) begin
         step();
         chk("nocarry_clr", 32'(bus.positions_clear), 32'd0);
         chk("nocarry_menu", 32'(bus.is_in_menu), 32'd1);
      end
      bus.btn_yellow = 1'b0;
      step();

      // Second race, simultaneous finish of green, blue, yellow.
      bus.btn_green = 1'b1;
      step();
      chk("p2_clr", 32'(bus.positions_clear), 32'd1);
      bus.btn_green = 1'b0;
      for (int k = 1; k < 12; k++) step();
      chk("p2_pre", 32'(bus.race_enable), 32'd0);
      step();
      chk("p2_race", 32'(bus.race_enable), 32'd1);
      bus.green_cur_pos  = 7'd108;
      bus.blue_cur_pos   = 7'd108;
      bus.yellow_cur_pos = 7'd108;
      step();
      chk("tie_win", 32'(bus.winner), 32'b0001);
      chk("tie_race", 32'(bus.race_enable), 32'd0);
      clear_pos();
      for (int k = 1; k < 8; k++) step();
      chk("p2_hold", 32'(bus.is_in_menu), 32'd0);
      step();
      chk("p2_menu", 32'(bus.is_in_menu), 32'd1);

      // Third race, reset asserted between edges mid-RACE.
      bus.btn_red = 1'b1;
      step();
      chk("p3_clr", 32'(bus.positions_clear), 32'd1);
      bus.btn_red = 1'b0;
      for (int k = 1; k < 14; k++) step();
      chk("p3_race", 32'(bus.race_enable), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_menu", 32'(bus.is_in_menu), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
